// File: rtl/trap_controller_if.sv
// ---------------------------------------------------------------------------
// trap_controller_if
// Bundles the CSR access bus and the trap/exception signals exchanged between
// the pipeline and trap_controller.
//   master : pipeline side; drives CSR requests, events, PCs and irq lines
//   slave  : trap_controller side; returns CSR read data, redirect and flushes
// CSR bus : csr_rw_in, csr_wsc_mode_in, csr_w_imm_mux, csr_rw_addr_in,
//           csr_w_data_reg, csr_w_data_imm -> csr_r_data_out
// Events  : irq[NUM_IRQ], illegal_inst, l_access_fault, s_access_fault,
//           ecall_m, mret, epc_cur, epc_next, fault_addr
// Control : PC_redirect, redirect_mux, reg_{FD,DE,EM,MW}_flush,
//           RegWrite_cancel, trap_busy
// ---------------------------------------------------------------------------
interface trap_controller_if #(
    parameter int unsigned NUM_IRQ = 4
);
    logic               csr_rw_in;
    logic [1:0]         csr_wsc_mode_in;
    logic               csr_w_imm_mux;
    logic [11:0]        csr_rw_addr_in;
    logic [31:0]        csr_w_data_reg;
    logic [4:0]         csr_w_data_imm;
    logic [31:0]        csr_r_data_out;

    logic [NUM_IRQ-1:0] irq;
    logic               illegal_inst;
    logic               l_access_fault;
    logic               s_access_fault;
    logic               ecall_m;
    logic               mret;
    logic [31:0]        epc_cur;
    logic [31:0]        epc_next;
    logic [31:0]        fault_addr;

    logic [31:0]        PC_redirect;
    logic               redirect_mux;
    logic               reg_FD_flush;
    logic               reg_DE_flush;
    logic               reg_EM_flush;
    logic               reg_MW_flush;
    logic               RegWrite_cancel;
    logic               trap_busy;

    modport master (
        output csr_rw_in, csr_wsc_mode_in, csr_w_imm_mux, csr_rw_addr_in,
               csr_w_data_reg, csr_w_data_imm,
               irq, illegal_inst, l_access_fault, s_access_fault, ecall_m,
               mret, epc_cur, epc_next, fault_addr,
        input  csr_r_data_out, PC_redirect, redirect_mux,
               reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush,
               RegWrite_cancel, trap_busy
    );

    modport slave (
        input  csr_rw_in, csr_wsc_mode_in, csr_w_imm_mux, csr_rw_addr_in,
               csr_w_data_reg, csr_w_data_imm,
               irq, illegal_inst, l_access_fault, s_access_fault, ecall_m,
               mret, epc_cur, epc_next, fault_addr,
        output csr_r_data_out, PC_redirect, redirect_mux,
               reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush,
               RegWrite_cancel, trap_busy
    );
endinterface

// File: rtl/trap_controller.sv
// ---------------------------------------------------------------------------
// trap_controller
// Machine-mode CSR file (mstatus, mie, mtvec, mepc, mcause, mtval, mip) plus a
// two-state trap FSM. Takes synchronous exceptions, local interrupts and MRET
// from the WB stage, flushes the pipeline and redirects the PC for one cycle.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : trap_controller_if.slave (CSR bus, events, redirect and flushes)
// ---------------------------------------------------------------------------
module trap_controller #(
    parameter int unsigned NUM_IRQ     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input logic              clk,
    input logic              rst,
    trap_controller_if.slave bus
);

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_e;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    // Architectural state
    state_e             state_q,        state_d;
    logic               mstatus_mie_q,  mstatus_mie_d;
    logic               mstatus_mpie_q, mstatus_mpie_d;
    logic [NUM_IRQ-1:0] mie_q,          mie_d;
    logic [31:0]        mtvec_q,        mtvec_d;
    logic [31:0]        mepc_q,         mepc_d;
    logic [31:0]        mcause_q,       mcause_d;
    logic [31:0]        mtval_q,        mtval_d;
    logic               redirect_mux_q, redirect_mux_d;
    logic [31:0]        pc_redirect_q,  pc_redirect_d;

    // Combinational helpers
    logic               is_idle;
    logic               exc_any;
    logic [NUM_IRQ-1:0] irq_en;
    logic               irq_pend;
    logic [3:0]         irq_idx;
    logic [4:0]         irq_code;
    logic               exc_take;
    logic               int_take;
    logic               mret_take;
    logic               trap_any;
    logic [31:0]        exc_cause;
    logic [31:0]        exc_tval;
    logic [31:0]        mtvec_base;
    logic [31:0]        int_target;
    logic [31:0]        csr_rdata;
    logic [31:0]        csr_src;
    logic [31:0]        csr_wdata;
    logic               csr_we;

    assign is_idle  = (state_q == IDLE);
    assign exc_any  = bus.illegal_inst | bus.ecall_m |
                      bus.l_access_fault | bus.s_access_fault;
    assign irq_en   = bus.irq & mie_q & {NUM_IRQ{mstatus_mie_q}};
    assign irq_pend = |irq_en;

    // Downward scan so the last assignment, the lowest set index, wins.
    always_comb begin
        irq_idx = '0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (irq_en[i-1]) begin
                irq_idx = 4'(i - 1);
            end
        end
    end

    // Interrupt cause/vector number is 16 + index.
    assign irq_code = {1'b1, irq_idx};

    assign exc_take  = is_idle & exc_any;
    assign int_take  = is_idle & ~exc_any & irq_pend;
    assign mret_take = is_idle & ~exc_any & ~irq_pend & bus.mret;
    assign trap_any  = exc_take | int_take | mret_take;

    always_comb begin
        exc_cause = '0;
        exc_tval  = bus.fault_addr;
        if (bus.illegal_inst) begin
            exc_cause = 32'd2;
        end else if (bus.ecall_m) begin
            exc_cause = 32'd11;
            exc_tval  = '0;
        end else if (bus.l_access_fault) begin
            exc_cause = 32'd5;
        end else if (bus.s_access_fault) begin
            exc_cause = 32'd7;
        end
    end

    assign mtvec_base = mtvec_q & ~32'h3;
    assign int_target = (mtvec_q[1:0] == 2'b01)
                      ? mtvec_base + {25'd0, irq_code, 2'b00}
                      : mtvec_base;

    // CSR read (pre-edge state)
    always_comb begin
        csr_rdata = '0;
        case (bus.csr_rw_addr_in)
            ADDR_MSTATUS: csr_rdata = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            ADDR_MIE:     csr_rdata = 32'(mie_q);
            ADDR_MTVEC:   csr_rdata = mtvec_q;
            ADDR_MEPC:    csr_rdata = mepc_q & ~32'h3;
            ADDR_MCAUSE:  csr_rdata = mcause_q;
            ADDR_MTVAL:   csr_rdata = mtval_q;
            ADDR_MIP:     csr_rdata = 32'(bus.irq);
            default:      csr_rdata = '0;
        endcase
    end

    assign csr_src = bus.csr_w_imm_mux ? {27'd0, bus.csr_w_data_imm} : bus.csr_w_data_reg;

    always_comb begin
        case (bus.csr_wsc_mode_in)
            2'b01:   csr_wdata = csr_src;
            2'b10:   csr_wdata = csr_rdata | csr_src;
            2'b11:   csr_wdata = csr_rdata & ~csr_src;
            default: csr_wdata = csr_rdata;
        endcase
    end

    // Set/clear with a zero source is a pure read; a taken trap discards the write.
    assign csr_we = bus.csr_rw_in & is_idle & ~trap_any &
                    ((bus.csr_wsc_mode_in == 2'b01) |
                     (bus.csr_wsc_mode_in[1] & (csr_src != '0)));

    // Next-state: CSR write first, trap updates override it.
    always_comb begin
        state_d        = IDLE;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        redirect_mux_d = 1'b0;
        pc_redirect_d  = '0;

        if (csr_we) begin
            case (bus.csr_rw_addr_in)
                ADDR_MSTATUS: begin
                    mstatus_mie_d  = csr_wdata[3];
                    mstatus_mpie_d = csr_wdata[7];
                end
                ADDR_MIE:    mie_d    = csr_wdata[NUM_IRQ-1:0];
                ADDR_MTVEC:  mtvec_d  = csr_wdata;
                ADDR_MEPC:   mepc_d   = csr_wdata;
                ADDR_MCAUSE: mcause_d = csr_wdata;
                ADDR_MTVAL:  mtval_d  = csr_wdata;
                default: ;
            endcase
        end

        if (exc_take) begin
            mepc_d         = bus.epc_cur;
            mcause_d       = exc_cause;
            mtval_d        = exc_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            state_d        = REDIRECT;
            redirect_mux_d = 1'b1;
            pc_redirect_d  = mtvec_base;
        end else if (int_take) begin
            mepc_d         = bus.epc_next;
            mcause_d       = {1'b1, 26'd0, irq_code};
            mtval_d        = '0;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            state_d        = REDIRECT;
            redirect_mux_d = 1'b1;
            pc_redirect_d  = int_target;
        end else if (mret_take) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
            state_d        = REDIRECT;
            redirect_mux_d = 1'b1;
            pc_redirect_d  = mepc_q & ~32'h3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            redirect_mux_q <= 1'b0;
            pc_redirect_q  <= '0;
        end else begin
            state_q        <= state_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            redirect_mux_q <= redirect_mux_d;
            pc_redirect_q  <= pc_redirect_d;
        end
    end

    assign bus.csr_r_data_out  = csr_rdata;
    assign bus.PC_redirect     = pc_redirect_q;
    assign bus.redirect_mux    = redirect_mux_q;
    assign bus.reg_FD_flush    = trap_any;
    assign bus.reg_DE_flush    = trap_any;
    assign bus.reg_EM_flush    = trap_any;
    assign bus.reg_MW_flush    = exc_take;
    assign bus.RegWrite_cancel = exc_take;
    assign bus.trap_busy       = (state_q == REDIRECT);

endmodule

// File: tb/tb_trap_controller.sv
// ---------------------------------------------------------------------------
// tb_trap_controller
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a behavioural model of the CSR file and trap rules; directed steps
// also pin key values to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_trap_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trap_controller_if #(.NUM_IRQ(4)) bus ();

    trap_controller #(.NUM_IRQ(4), .MTVEC_RESET(32'h0000_0200)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    bit          m_mie, m_mpie, m_busy;
    logic [3:0]  m_mie_r;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_target;

    // Event decision for the current cycle: 0 none, 1 exception, 2 irq, 3 mret
    int          k_kind;
    logic [31:0] k_cause, k_tval;
    int          k_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_busy = 0;
        m_mie_r = '0; m_mtvec = 32'h200; m_mepc = '0;
        m_mcause = '0; m_mtval = '0; m_target = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
            12'h304: return 32'(m_mie_r);
            12'h305: return m_mtvec;
            12'h341: return m_mepc & 32'hFFFF_FFFC;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return 32'(bus.irq);
            default: return 32'h0;
        endcase
    endfunction

    task automatic classify();
        logic [3:0] pend;
        pend    = bus.irq & m_mie_r;
        k_kind  = 0; k_cause = '0; k_tval = '0; k_irq = -1;
        if (m_mie) begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && k_irq < 0) k_irq = i;
            end
        end
        if (m_busy)                    k_kind = 0;
        else if (bus.illegal_inst)     begin k_kind = 1; k_cause = 2;  k_tval = bus.fault_addr; end
        else if (bus.ecall_m)          begin k_kind = 1; k_cause = 11; k_tval = 0; end
        else if (bus.l_access_fault)   begin k_kind = 1; k_cause = 5;  k_tval = bus.fault_addr; end
        else if (bus.s_access_fault)   begin k_kind = 1; k_cause = 7;  k_tval = bus.fault_addr; end
        else if (k_irq >= 0)           k_kind = 2;
        else if (bus.mret)             k_kind = 3;
    endtask

    task automatic compare();
        bit any, exc;
        classify();
        any = (k_kind != 0);
        exc = (k_kind == 1);
        check("csr_r_data", bus.csr_r_data_out, m_read(bus.csr_rw_addr_in));
        check("PC_redirect", bus.PC_redirect, m_busy ? m_target : 32'h0);
        check("redirect_mux", 32'(bus.redirect_mux), 32'(m_busy));
        check("trap_busy", 32'(bus.trap_busy), 32'(m_busy));
        check("FD_flush", 32'(bus.reg_FD_flush), 32'(any));
        check("DE_flush", 32'(bus.reg_DE_flush), 32'(any));
        check("EM_flush", 32'(bus.reg_EM_flush), 32'(any));
        check("MW_flush", 32'(bus.reg_MW_flush), 32'(exc));
        check("RegWrite_cancel", 32'(bus.RegWrite_cancel), 32'(exc));
    endtask

    task automatic model_update();
        logic [31:0] src, old, nv, base;
        bit          wr;
        classify();
        base = m_mtvec & 32'hFFFF_FFFC;
        if (rst) begin
            model_reset();
        end else if (m_busy) begin
            m_busy = 0;
        end else if (k_kind == 1) begin
            m_mepc = bus.epc_cur; m_mcause = k_cause; m_mtval = k_tval;
            m_mpie = m_mie; m_mie = 0; m_busy = 1; m_target = base;
        end else if (k_kind == 2) begin
            m_mepc = bus.epc_next; m_mcause = 32'h8000_0000 + 32'(16 + k_irq);
            m_mtval = 0; m_mpie = m_mie; m_mie = 0; m_busy = 1;
            m_target = (m_mtvec[1:0] == 2'b01) ? base + 32'(4 * (16 + k_irq)) : base;
        end else if (k_kind == 3) begin
            m_mie = m_mpie; m_mpie = 1; m_busy = 1; m_target = m_mepc & 32'hFFFF_FFFC;
        end else if (bus.csr_rw_in) begin
            src = bus.csr_w_imm_mux ? 32'(bus.csr_w_data_imm) : bus.csr_w_data_reg;
            old = m_read(bus.csr_rw_addr_in);
            nv  = old; wr = 0;
            case (bus.csr_wsc_mode_in)
                2'b01: begin nv = src;        wr = 1; end
                2'b10: begin nv = old | src;  wr = (src != 0); end
                2'b11: begin nv = old & ~src; wr = (src != 0); end
                default: wr = 0;
            endcase
            if (wr) begin
                case (bus.csr_rw_addr_in)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h304: m_mie_r  = nv[3:0];
                    12'h305: m_mtvec  = nv;
                    12'h341: m_mepc   = nv;
                    12'h342: m_mcause = nv;
                    12'h343: m_mtval  = nv;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic idle_inputs();
        bus.csr_rw_in = 0; bus.csr_wsc_mode_in = 0; bus.csr_w_imm_mux = 0;
        bus.csr_rw_addr_in = 12'h000; bus.csr_w_data_reg = 0; bus.csr_w_data_imm = 0;
        bus.irq = 0; bus.illegal_inst = 0; bus.l_access_fault = 0;
        bus.s_access_fault = 0; bus.ecall_m = 0; bus.mret = 0;
        bus.epc_cur = 0; bus.epc_next = 0; bus.fault_addr = 0;
    endtask

    task automatic settle();
        @(negedge clk);
        compare();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic csr_write(input logic [1:0] mode, input logic [11:0] addr, input logic [31:0] data);
        idle_inputs();
        bus.csr_rw_in = 1; bus.csr_wsc_mode_in = mode;
        bus.csr_rw_addr_in = addr; bus.csr_w_data_reg = data;
        cycle();
        idle_inputs();
    endtask

    // Read a CSR in a quiet cycle and pin it to a literal.
    task automatic read_pin(input string name, input logic [11:0] addr, input logic [31:0] exp);
        idle_inputs();
        bus.csr_rw_addr_in = addr;
        settle();
        check(name, bus.csr_r_data_out, exp);
        advance();
    endtask

    logic [11:0] addr_pool [9] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                                   12'h343, 12'h344, 12'h7C0, 12'h001};

    initial begin
        idle_inputs();
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        cycle();                      // one more reset cycle, now checked
        rst = 0;

        // Reset state
        read_pin("rst_mtvec", 12'h305, 32'h0000_0200);
        read_pin("rst_mstatus", 12'h300, 32'h0);

        // Scenario 1: mtvec=0x100, illegal instruction
        csr_write(2'b01, 12'h305, 32'h100);
        bus.illegal_inst = 1; bus.epc_cur = 32'h40; bus.fault_addr = 32'hDEAD;
        settle();
        check("s1_MW_flush", 32'(bus.reg_MW_flush), 32'h1);
        check("s1_cancel", 32'(bus.RegWrite_cancel), 32'h1);
        advance();
        idle_inputs(); bus.csr_rw_addr_in = 12'h341;
        settle();
        check("s1_redirect", 32'(bus.redirect_mux), 32'h1);
        check("s1_pc", bus.PC_redirect, 32'h100);
        check("s1_mepc", bus.csr_r_data_out, 32'h40);
        advance();
        read_pin("s1_mcause", 12'h342, 32'h2);
        read_pin("s1_mtval", 12'h343, 32'hDEAD);

        // Scenario 2: vectored interrupt
        csr_write(2'b01, 12'h305, 32'h101);
        csr_write(2'b01, 12'h304, 32'h4);
        csr_write(2'b01, 12'h300, 32'h8);
        bus.irq = 4'h6; bus.epc_next = 32'h88;
        settle();
        check("s2_cancel", 32'(bus.RegWrite_cancel), 32'h0);
        check("s2_MW_flush", 32'(bus.reg_MW_flush), 32'h0);
        check("s2_FD_flush", 32'(bus.reg_FD_flush), 32'h1);
        advance();
        idle_inputs(); bus.csr_rw_addr_in = 12'h342;
        settle();
        check("s2_pc", bus.PC_redirect, 32'h148);
        check("s2_mcause", bus.csr_r_data_out, 32'h8000_0012);
        advance();
        read_pin("s2_mepc", 12'h341, 32'h88);
        read_pin("s2_mstatus", 12'h300, 32'h80);

        // Scenario 3: mret
        bus.mret = 1;
        settle();
        check("s3_MW_flush", 32'(bus.reg_MW_flush), 32'h0);
        check("s3_EM_flush", 32'(bus.reg_EM_flush), 32'h1);
        advance();
        idle_inputs();
        settle();
        check("s3_pc", bus.PC_redirect, 32'h88);
        advance();
        read_pin("s3_mstatus", 12'h300, 32'h88);

        // Scenario 4: ecall + load fault + pending irq together
        bus.ecall_m = 1; bus.l_access_fault = 1; bus.irq = 4'h4; bus.fault_addr = 32'h1234;
        cycle();
        idle_inputs();
        settle();
        check("s4_redirect", 32'(bus.redirect_mux), 32'h1);
        advance();
        bus.csr_rw_addr_in = 12'h342;
        settle();
        check("s4_single", 32'(bus.redirect_mux), 32'h0);
        check("s4_mcause", bus.csr_r_data_out, 32'd11);
        advance();
        read_pin("s4_mtval", 12'h343, 32'h0);

        // Scenario 5: set with zero source, clear dropped by concurrent trap
        idle_inputs();
        bus.csr_rw_in = 1; bus.csr_wsc_mode_in = 2'b10; bus.csr_w_imm_mux = 1;
        bus.csr_w_data_imm = 5'd0; bus.csr_rw_addr_in = 12'h304;
        cycle();
        read_pin("s5_mie", 12'h304, 32'h4);
        csr_write(2'b01, 12'h300, 32'h8);
        bus.csr_rw_in = 1; bus.csr_wsc_mode_in = 2'b11; bus.csr_rw_addr_in = 12'h300;
        bus.csr_w_data_reg = 32'h8; bus.illegal_inst = 1;
        cycle();
        read_pin("s5_mstatus", 12'h300, 32'h80);

        // Scenario 6: reset during REDIRECT
        bus.illegal_inst = 1;
        cycle();
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;
        settle();
        check("s6_redirect", 32'(bus.redirect_mux), 32'h0);
        check("s6_pc", bus.PC_redirect, 32'h0);
        advance();
        read_pin("s6_mstatus", 12'h300, 32'h0);
        read_pin("s6_mie", 12'h304, 32'h0);
        read_pin("s6_mtvec", 12'h305, 32'h200);
        read_pin("s6_mepc", 12'h341, 32'h0);
        read_pin("s6_mcause", 12'h342, 32'h0);
        read_pin("s6_mtval", 12'h343, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            rst = ($urandom_range(0, 299) == 0);
            if (!rst) begin
                bus.csr_rw_in       = $urandom_range(0, 1) != 0;
                bus.csr_wsc_mode_in = 2'($urandom_range(0, 3));
                bus.csr_w_imm_mux   = $urandom_range(0, 1) != 0;
                bus.csr_w_data_reg  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                bus.csr_w_data_imm  = 5'($urandom);
                bus.illegal_inst    = ($urandom_range(0, 15) == 0);
                bus.ecall_m         = ($urandom_range(0, 15) == 0);
                bus.l_access_fault  = ($urandom_range(0, 15) == 0);
                bus.s_access_fault  = ($urandom_range(0, 15) == 0);
                bus.mret            = ($urandom_range(0, 7) == 0);
                bus.irq             = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                bus.epc_cur         = $urandom;
                bus.epc_next        = $urandom;
                bus.fault_addr      = $urandom;
            end
            bus.csr_rw_addr_in = addr_pool[$urandom_range(0, 8)];
            cycle();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
